// File: rtl/keypad_matrix_scanner_pkg.sv
//------------------------------------------------------------------------------
// Module : keypad_pkg
// Brief  : Shared keypad geometry constants and key-index helper.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package keypad_pkg;

  localparam int NUM_ROWS   = 4;
  localparam int NUM_COLS   = 4;
  localparam int KEY_CODE_W = 4;
  localparam int NUM_KEYS   = NUM_ROWS * NUM_COLS;

  function automatic logic [KEY_CODE_W-1:0] key_index(input int unsigned row,
                                                      input int unsigned col);
    return KEY_CODE_W'(row * NUM_COLS + col);
  endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_matrix_scanner_prio_enc.sv
//------------------------------------------------------------------------------
// Module : keypad_prio_enc
// Brief  : 16-to-4 lowest-index priority encoder with any-set flag.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module keypad_prio_enc
  import keypad_pkg::*;
(
  input  logic [NUM_KEYS-1:0]   i_map,
  output logic [KEY_CODE_W-1:0] o_code,
  output logic                  o_any
);

  // Scan from the top down so the lowest set index is the last assignment.
  always_comb begin
    o_code = '0;
    for (int r = NUM_ROWS - 1; r >= 0; r--) begin
      for (int c = NUM_COLS - 1; c >= 0; c--) begin
        if (i_map[r*NUM_COLS + c]) begin
          o_code = key_index(r, c);
        end
      end
    end
    o_any = |i_map;
  end

endmodule

`default_nettype wire

// File: rtl/keypad_matrix_scanner.sv
//------------------------------------------------------------------------------
// Module : keypad_matrix_scanner
// Brief  : 4x4 keypad row scanner with frame debounce and hex key encoding.
//          Define KEYPAD_BITMAP_EN to drive key_map with the debounced bitmap.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int DIV_BITS        = 16,
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_COLS-1:0]   col_n,
  output logic [NUM_ROWS-1:0]   row_n,
  output logic [KEY_CODE_W-1:0] key_code,
  output logic                  key_pressed,
  output logic                  key_valid,
  output logic [NUM_KEYS-1:0]   key_map
);

  localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CNT_W:0]   DEB_THRESH = DEBOUNCE_FRAMES[CNT_W:0];
  localparam logic [CNT_W-1:0] CNT_SAT    = DEBOUNCE_FRAMES[CNT_W-1:0];

  logic [NUM_COLS-1:0]   r_sync1;
  logic [NUM_COLS-1:0]   r_sync2;
  logic [DIV_BITS-1:0]   r_presc;
  logic [1:0]            r_row_idx;
  logic [NUM_KEYS-1:0]   r_frame_map;
  logic [NUM_KEYS-1:0]   r_prev_map;
  logic [NUM_KEYS-1:0]   r_stable_map;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_stable_chg;

  logic                  w_tick;
  logic                  w_frame_end;
  logic [1:0]            w_row_next;
  logic [3:0]            w_base;
  logic [NUM_KEYS-1:0]   w_frame_new;
  logic [CNT_W:0]        w_cnt_inc;
  logic [KEY_CODE_W-1:0] w_code;
  logic                  w_any;

  assign w_tick      = &r_presc;
  assign w_frame_end = w_tick && (r_row_idx == 2'd3);
  assign w_row_next  = r_row_idx + 2'd1;
  assign w_base      = {r_row_idx, 2'b00};
  assign w_cnt_inc   = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};

  // Frame map as it will look after this tick, so frame end sees the full frame.
  always_comb begin
    w_frame_new                     = r_frame_map;
    w_frame_new[w_base +: NUM_COLS] = ~r_sync2;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1      <= '1;
      r_sync2      <= '1;
      r_presc      <= '0;
      r_row_idx    <= '0;
      row_n        <= 4'b1110;
      r_frame_map  <= '0;
      r_prev_map   <= '0;
      r_stable_map <= '0;
      r_cnt        <= '0;
      r_stable_chg <= 1'b0;
    end else begin
      r_sync1      <= col_n;
      r_sync2      <= r_sync1;
      r_presc      <= r_presc + DIV_BITS'(1);
      r_stable_chg <= 1'b0;
      if (w_tick) begin
        r_frame_map <= w_frame_new;
        r_row_idx   <= w_row_next;
        row_n       <= ~(4'b0001 << w_row_next);
      end
      if (w_frame_end) begin
        r_prev_map <= w_frame_new;
        if (w_frame_new == r_prev_map) begin
          if (w_cnt_inc >= DEB_THRESH) begin
            r_cnt        <= CNT_SAT;
            r_stable_map <= w_frame_new;
            r_stable_chg <= (w_frame_new != r_stable_map);
          end else begin
            r_cnt <= w_cnt_inc[CNT_W-1:0];
          end
        end else begin
          r_cnt <= '0;
        end
      end
    end
  end

  keypad_prio_enc u_prio_enc (
    .i_map  (r_stable_map),
    .o_code (w_code),
    .o_any  (w_any)
  );

  // key_pressed still reflects the previous map here, so !key_pressed means "was empty".
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_code    <= '0;
      key_pressed <= 1'b0;
      key_valid   <= 1'b0;
    end else begin
      key_pressed <= w_any;
      key_valid   <= r_stable_chg && w_any && ((w_code != key_code) || !key_pressed);
      if (w_any) begin
        key_code <= w_code;
      end
    end
  end

`ifdef KEYPAD_BITMAP_EN
  logic [NUM_KEYS-1:0] r_key_map;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_key_map <= '0;
    end else begin
      r_key_map <= r_stable_map;
    end
  end

  assign key_map = r_key_map;
`else
  assign key_map = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_keypad_matrix_scanner.sv
//------------------------------------------------------------------------------
// Module : tb_keypad_matrix_scanner
// Brief  : Scoreboard bench for keypad_matrix_scanner with a behavioural keypad.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_keypad_matrix_scanner;

  localparam int DIV_BITS = 2;
  localparam int DEB      = 2;
  localparam int FRAME    = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic [3:0]  key_code;
  logic        key_pressed;
  logic        key_valid;
  logic [15:0] key_map;
  logic [15:0] keys;
  logic [15:0] exp_map;
  logic [3:0]  exp_row;

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  // Keypad model: a held key pulls its column low while its row is driven.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!row_n[r] && keys[r*4 + c]) col_n[c] = 1'b0;
      end
    end
  end

  keypad_matrix_scanner #(
    .DIV_BITS        (DIV_BITS),
    .DEBOUNCE_FRAMES (DEB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .col_n       (col_n),
    .row_n       (row_n),
    .key_code    (key_code),
    .key_pressed (key_pressed),
    .key_valid   (key_valid),
    .key_map     (key_map)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the next queued expectation.
  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got code %h expected no strobe", key_code);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        check("strobe_code", 32'(key_code), 32'(e));
        check("strobe_pressed", 32'(key_pressed), 32'd1);
      end
    end
  end

  task automatic frames(input int n);
    repeat (n * FRAME) @(negedge clk);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    keys  = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset in the middle of a scan
    repeat (7) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_row_n", 32'(row_n), 32'h0000000E);
    check("rst_valid", 32'(key_valid), 32'd0);
    check("rst_pressed", 32'(key_pressed), 32'd0);
    check("rst_code", 32'(key_code), 32'd0);
    check("rst_map", 32'(key_map), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("row0_dwell", 32'(row_n), 32'h0000000E);
    @(negedge clk);
    check("row1_first", 32'(row_n), 32'h0000000D);
    for (int k = 0; k < 12; k++) begin
      repeat (4) @(negedge clk);
      exp_row = ~(4'b0001 << ((k + 2) % 4));
      check("row_cycle", 32'(row_n), 32'(exp_row));
    end
    frames(17);

    // Single key row2/col1
    keys[9] = 1'b1;
    exp_q.push_back(4'h9);
    wait_drain("press9_latency", 5 * FRAME);
    check("press9_pressed", 32'(key_pressed), 32'd1);
    check("press9_code", 32'(key_code), 32'h9);
    frames(10);
    keys = '0;
    frames(6);
    check("rel9_pressed", 32'(key_pressed), 32'd0);
    check("rel9_code", 32'(key_code), 32'h9);

    // Bounce then hold
    for (int i = 0; i < 6; i++) begin
      keys[9] = ~keys[9];
      frames(1);
    end
    check("bounce_no_press", 32'(key_pressed), 32'd0);
    keys[9] = 1'b1;
    exp_q.push_back(4'h9);
    wait_drain("bounce_latency", 6 * FRAME);
    frames(4);
    keys = '0;
    frames(6);

    // Two keys together, then release the lower one, then all
    keys = 16'h0208;
    exp_q.push_back(4'h3);
    wait_drain("chord_latency", 6 * FRAME);
    check("chord_code", 32'(key_code), 32'h3);
    keys = 16'h0200;
    exp_q.push_back(4'h9);
    wait_drain("rel3_latency", 6 * FRAME);
    check("rel3_code", 32'(key_code), 32'h9);
    keys = '0;
    frames(6);
    check("relall_pressed", 32'(key_pressed), 32'd0);
    check("relall_code", 32'(key_code), 32'h9);

    // Adding a higher key under a held lower key gives no strobe
    keys = 16'h0008;
    exp_q.push_back(4'h3);
    wait_drain("press3_latency", 6 * FRAME);
    keys = 16'h0208;
    frames(6);
    check("addhigh_code", 32'(key_code), 32'h3);
    check("addhigh_pressed", 32'(key_pressed), 32'd1);
    keys = '0;
    frames(6);

    // Corner keys and the optional bitmap
    keys = 16'h8001;
    exp_q.push_back(4'h0);
    wait_drain("corner_latency", 6 * FRAME);
    check("corner_code", 32'(key_code), 32'h0);
`ifdef KEYPAD_BITMAP_EN
    exp_map = 16'h8001;
`else
    exp_map = 16'h0000;
`endif
    check("corner_map", 32'(key_map), 32'(exp_map));

    // Reset while keys are held clears everything at once
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst2_pressed", 32'(key_pressed), 32'd0);
    check("rst2_map", 32'(key_map), 32'd0);
    check("rst2_row_n", 32'(row_n), 32'h0000000E);
    keys = '0;
    @(negedge clk);
    reset = 1'b0;
    frames(4);
    check("final_queue", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
